// File: rtl/bcd_inc_sequencer.sv
// 3-digit BCD counter storage with a shared one-digit-per-cycle increment FSM,
// arbitrating switch load, manual step and prescaler-driven auto-run.
module bcd_inc_sequencer #(
  parameter int unsigned PRESCALE = 100_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        step,
  input  logic        run,
  input  logic        clr_ovf,
  output logic [11:0] bcd_q,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        invalid
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);

  typedef enum logic [1:0] {IDLE, INC0, INC1, INC2} state_t;

  state_t           state;
  logic [CNT_W-1:0] pcnt;
  logic             pending;
  logic             tick;
  logic             req;
  logic             nib_ok;
  logic             load_ok;
  logic             carry;
  logic [11:0]      inc_val;

  // {carry, next digit} for a single BCD digit increment
  function automatic logic [4:0] bump(input logic [3:0] d);
    return (d == 4'd9) ? 5'b1_0000 : {1'b0, d + 4'd1};
  endfunction

  always_comb begin
    tick    = run && (pcnt == CNT_W'(PRESCALE - 1));
    req     = step | tick | pending;
    nib_ok  = (load_val[3:0] <= 4'd9) && (load_val[7:4] <= 4'd9) &&
              (load_val[11:8] <= 4'd9);
    load_ok = load & nib_ok;
  end

  // Only the digit addressed by the current state is rewritten.
  always_comb begin
    inc_val = bcd_q;
    carry   = 1'b0;
    unique case (state)
      INC0:    {carry, inc_val[3:0]}  = bump(bcd_q[3:0]);
      INC1:    {carry, inc_val[7:4]}  = bump(bcd_q[7:4]);
      INC2:    {carry, inc_val[11:8]} = bump(bcd_q[11:8]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (!run || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bcd_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      invalid <= 1'b0;
      pending <= 1'b0;
    end else begin
      done    <= 1'b0;
      invalid <= load & ~nib_ok;
      if (clr_ovf) ovf <= 1'b0;
      if (load_ok) begin
        state   <= IDLE;
        busy    <= 1'b0;
        bcd_q   <= load_val;
        pending <= 1'b0;
      end else if (state == IDLE) begin
        if (req) begin
          state   <= INC0;
          busy    <= 1'b1;
          pending <= 1'b0;
        end
      end else begin
        if (step | tick) pending <= 1'b1;
        bcd_q <= inc_val;
        if (carry && state != INC2) begin
          state <= (state == INC0) ? INC1 : INC2;
        end else begin
          // A carry out of the top digit is the 999->000 wrap; it overrides clr_ovf.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (carry) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_inc_sequencer.sv
// Self-checking bench for bcd_inc_sequencer: directed scenarios plus random
// traffic, compared every cycle against a decimal-arithmetic reference model.
module tb_bcd_inc_sequencer;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [11:0] load_val;
  logic        step;
  logic        run;
  logic        clr_ovf;
  logic [11:0] bcd_q;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        invalid;

  bcd_inc_sequencer #(.PRESCALE(P)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .run      (run),
    .clr_ovf  (clr_ovf),
    .bcd_q    (bcd_q),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: value kept as a decimal integer 0..999.
  int m_val, m_start, m_ncyc, m_j, m_pcnt;
  bit m_busy, m_pend, m_ovf, m_done, m_inv;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Cycles needed: one per trailing 9 plus the final digit, at most three digits.
  function automatic int inc_cycles(input int v);
    if (v % 10 != 9) return 1;
    if ((v / 10) % 10 != 9) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_val = 0; m_busy = 0; m_pend = 0; m_ovf = 0;
    m_done = 0; m_inv = 0; m_pcnt = 0; m_j = 0; m_ncyc = 0; m_start = 0;
  endtask

  task automatic model_edge();
    bit tick, valid, wrap;
    tick  = run && (m_pcnt == P - 1);
    valid = (load_val[11:8] <= 9) && (load_val[7:4] <= 9) && (load_val[3:0] <= 9);
    wrap  = 0;
    m_pcnt = run ? (m_pcnt + 1) % P : 0;
    m_done = 0;
    m_inv  = load && !valid;
    if (load && valid) begin
      m_val = from_bcd(load_val); m_busy = 0; m_pend = 0;
    end else if (!m_busy) begin
      if (step || tick || m_pend) begin
        m_start = m_val; m_ncyc = inc_cycles(m_val); m_j = 0;
        m_busy = 1; m_pend = 0;
      end
    end else begin
      if (step || tick) m_pend = 1;
      m_j++;
      if (m_j == m_ncyc) begin
        m_val  = (m_start + 1) % 1000;
        m_done = 1;
        m_busy = 0;
        wrap   = (m_start == 999);
      end else begin
        m_val = m_start - (10 ** m_j - 1);
      end
    end
    if (wrap) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  task automatic compare();
    check("bcd_q", bcd_q, to_bcd(m_val));
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("ovf", ovf, m_ovf);
    check("invalid", invalid, m_inv);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input bit ld, input logic [11:0] lv, input bit st, input bit clr);
    load = ld; load_val = lv; step = st; clr_ovf = clr;
    cycle();
    load = 0; step = 0; clr_ovf = 0;
  endtask

  task automatic run_inc(input logic [11:0] lv, input logic [11:0] exp, input int exp_busy);
    int nb, nd;
    drive(1, lv, 0, 0);
    drive(0, lv, 1, 0);
    nb = int'(busy);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      nb += int'(busy);
      nd += int'(done);
    end
    check("inc_final", bcd_q, exp);
    check("inc_busy_cycles", nb, exp_busy);
    check("inc_done_pulses", nd, 1);
  endtask

  initial begin
    logic [11:0] vals [3];
    int nd;
    reset_n = 0; load = 0; load_val = '0; step = 0; run = 0; clr_ovf = 0;
    model_reset();
    #12;
    check("rst_bcd_q", bcd_q, 12'h000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_invalid", invalid, 0);
    reset_n = 1;
    cycle();

    run_inc(12'h123, 12'h124, 1);
    check("no_ovf_123", ovf, 0);
    run_inc(12'h199, 12'h200, 3);

    run_inc(12'h999, 12'h000, 3);
    check("wrap_ovf", ovf, 1);
    repeat (3) cycle();
    check("ovf_sticky", ovf, 1);
    drive(0, 12'h000, 0, 1);
    check("ovf_cleared", ovf, 0);

    drive(1, 12'h999, 0, 0);
    drive(0, 12'h999, 1, 0);
    cycle();
    cycle();
    clr_ovf = 1;
    cycle();
    clr_ovf = 0;
    check("wrap_vs_clr_val", bcd_q, 12'h000);
    check("wrap_vs_clr_ovf", ovf, 1);
    cycle();

    drive(1, 12'h1A3, 0, 0);
    check("inv_pulse", invalid, 1);
    check("inv_keep", bcd_q, 12'h000);
    check("inv_busy", busy, 0);
    cycle();
    check("inv_once", invalid, 0);

    drive(1, 12'h099, 0, 0);
    drive(0, 12'h099, 1, 0);
    drive(0, 12'h099, 1, 0);
    drive(0, 12'h099, 1, 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      nd += int'(done);
    end
    check("b2b_final", bcd_q, 12'h101);
    check("b2b_dones", nd, 2);

    drive(1, 12'h008, 0, 0);
    run = 1;
    nd = 0;
    for (int i = 0; i < 13; i++) begin
      cycle();
      if (done && nd < 3) begin
        vals[nd] = bcd_q;
        nd++;
      end
    end
    check("run_ticks", nd, 3);
    check("run_v0", vals[0], 12'h009);
    check("run_v1", vals[1], 12'h010);
    check("run_v2", vals[2], 12'h011);
    run = 0;
    repeat (10) cycle();
    check("run_stopped", bcd_q, 12'h011);
    run = 1;
    repeat (6) cycle();
    run = 0;
    repeat (4) cycle();

    drive(1, 12'h199, 0, 0);
    drive(0, 12'h199, 1, 0);
    cycle();
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check("async_rst_bcd_q", bcd_q, 12'h000);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    #1;
    reset_n = 1;
    repeat (2) cycle();

    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      load_val = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      if ($urandom_range(0, 3) == 0) load_val = 12'h999;
      step     = ($urandom_range(0, 3) == 0);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      cycle();
    end
    load = 0; step = 0; clr_ovf = 0; run = 0;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_inc_sequencer.md
Name: bcd_inc_sequencer

Overview:
- Sequencer and storage for a 3-digit BCD counter that feeds the seven-segment time-multiplexed display path.
- Arbitrates among three requesters for one shared 4-bit digit-increment step: switch load, manual step pulse, and free-running prescaler tick.
- Performs the increment as a one-digit-per-cycle ripple FSM.
- Presents the held value, status flags and handshake outputs to the display top level.

Parameters:
- PRESCALE, 100_000_000, clk cycles between auto-run ticks; 1 Hz at 100 MHz. Benches override it to a small value. Legal range ≥ 2.
- CNT_W, $clog2(PRESCALE), prescaler counter width. Derived; never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- load  in  1  single-cycle request: replace value with load_val.
- load_val  in  12  candidate value, {digit2, digit1, digit0}, 4 bits each.
- step  in  1  single-cycle request: increment by one.
- run  in  1  level: enables prescaler auto-increment.
- clr_ovf  in  1  single-cycle: clear sticky ovf.
- bcd_q  out  12  current value, {digit2, digit1, digit0}.
- busy  out  1  high while the FSM is not IDLE.
- done  out  1  one-cycle pulse after an increment completes.
- ovf  out  1  sticky flag: counter wrapped 999→000.
- invalid  out  1  one-cycle pulse: load rejected, some nibble > 9.

Behaviour:
- Reset, while reset_n = 0:
  - bcd_q = 12'h000; busy, done, ovf, invalid = 0.
  - FSM = IDLE; prescaler = 0; pending = 0.
- All state is registered.
- Prescaler:
  - While run = 1, counts 0..PRESCALE-1 and wraps.
  - tick = 1 for the one cycle in which count == PRESCALE-1.
  - run = 0 holds the count at 0 and gives no tick.
- FSM states: IDLE, INC0, INC1, INC2. busy = (state != IDLE).
- Increment request (req) = step | tick | pending.
- IDLE:
  - If load is valid: bcd_q <= load_val at this edge; no increment starts; pending cleared.
  - Else if req: state <= INC0 and pending cleared.
  - load takes priority over req.
- INCk (k = 0, 1, 2):
  - If digit k == 9: digit k <= 0. For k < 2, state <= INC(k+1). For k = 2, state <= IDLE, ovf <= 1, done pulses.
  - Else: digit k <= digit k + 1, state <= IDLE, done pulses.
  - Only one digit is written per cycle.
- Latency, with the request sampled at edge e0:
  - No carry: bcd_q updates at e1 and done is high for the cycle after e1.
  - One carry: updates at e2.
  - Two carries: updates at e3.
- Requests while busy:
  - step or tick sets pending; it is one deep and further requests are dropped.
  - pending starts the next increment immediately on return to IDLE, so there is no idle gap beyond the IDLE cycle itself.
- Load validity and load while busy:
  - Load is valid when all three nibbles are ≤ 9.
  - An invalid load pulses invalid at the next cycle, leaves bcd_q unchanged and never aborts.
  - A valid load while busy aborts the increment: state <= IDLE, bcd_q <= load_val, pending cleared, no done, no ovf update.
- ovf:
  - Sticky until clr_ovf.
  - If clr_ovf coincides with a new 999→000 wrap, set wins.
- Reset mid-increment returns everything to reset values immediately (asynchronous) and discards any partial carry.
- bcd_q is never observed holding a non-BCD nibble.

Test Plan:
- Reset, load 12'h123, step → bcd_q = 12'h124 one edge after step is sampled; busy high 1 cycle; done pulses once; ovf = 0.
- Load 12'h199, step → intermediate 12'h190, then 12'h100, then 12'h200 three edges after sampling; busy high 3 cycles; done after the final write.
- Load 12'h999, step → 12'h000, ovf = 1 and stays 1. Then clr_ovf → 0. Repeat with clr_ovf asserted on the wrap edge → ovf remains 1.
- Load 12'h1A3 → invalid pulses one cycle, bcd_q unchanged at prior value, busy stays 0.
- Load 12'h099, step, then step again while busy → first result 12'h100, second result 12'h101 follows back-to-back; a third step in the same busy window is dropped, final value 12'h101.
- PRESCALE = 4, run = 1 from 12'h008 → ticks every 4 cycles, values 009, 010, 011. Deassert run mid-count → no further ticks, prescaler at 0. Assert reset_n = 0 during INC1 → bcd_q = 000, busy = 0 asynchronously.
